// File: rtl/matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scanner
// Description : Row-multiplexed LED matrix scanner. Snapshots the framebuffer
//               at the start of each frame, shifts one row of column data out
//               serially (MSB first), latches it into the column drivers and
//               then lights that row for a fixed dwell time.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scanner #(
   parameter int ROWS    = 8,
   parameter int COLS    = 16,
   parameter int CLK_DIV = 2,
   parameter int DWELL   = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ROWS*COLS-1:0] frame,
   input  logic                 enable,
   output logic                 sclk,
   output logic                 sdata,
   output logic                 latch,
   output logic [ROWS-1:0]      row_sel,
   output logic                 blank,
   output logic                 frame_start
);

   localparam int ROW_W = (ROWS > 1)      ? $clog2(ROWS)      : 1;
   localparam int BIT_W = (COLS > 1)      ? $clog2(COLS)      : 1;
   localparam int DIV_W = (CLK_DIV > 1)   ? $clog2(CLK_DIV)   : 1;
   localparam int DWL_W = (DWELL > 1)     ? $clog2(DWELL)     : 1;
   localparam int IDX_W = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1;

   localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(COLS - 1);
   localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DWL_W-1:0] c_DWL_LAST = DWL_W'(DWELL - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SNAP  = 3'd1,
      S_SHIFT = 3'd2,
      S_LATCH = 3'd3,
      S_DWELL = 3'd4
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [ROW_W-1:0]       r_row;
   logic [ROWS*COLS-1:0]   r_snap;
   logic [COLS-1:0]        r_shift;
   logic [DIV_W-1:0]       r_div;
   logic                   r_phase;     // 0 = sclk low half, 1 = sclk high half
   logic [BIT_W-1:0]       r_bit;
   logic [DWL_W-1:0]       r_dwell;

   logic                   w_row_zero;
   logic                   w_div_last;
   logic                   w_shift_done;
   logic                   w_dwell_last;
   logic [ROWS*COLS-1:0]   w_src;
   logic [IDX_W-1:0]       w_base;
   logic [COLS-1:0]        w_row_bits;

   assign w_row_zero   = (r_row == '0);
   assign w_div_last   = (r_div == c_DIV_LAST);
   assign w_shift_done = w_div_last & r_phase & (r_bit == c_BIT_LAST);
   assign w_dwell_last = (r_dwell == c_DWL_LAST);

   // Row 0 loads straight from the live framebuffer because the snapshot
   // register is only updated at the end of that same SNAP cycle.
   assign w_src      = w_row_zero ? frame : r_snap;
   assign w_base     = IDX_W'(r_row) * IDX_W'(COLS);
   assign w_row_bits = w_src[w_base +: COLS];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Datapath: snapshot, shift register, bit timing and row/dwell counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row   <= '0;
         r_snap  <= '1;
         r_shift <= '0;
         r_div   <= '0;
         r_phase <= 1'b0;
         r_bit   <= '0;
         r_dwell <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_row <= '0;
            end
            S_SNAP: begin
               if (w_row_zero) r_snap <= frame;
               r_shift <= ~w_row_bits;          // framebuffer 0 = lit, driver 1 = on
               r_div   <= '0;
               r_phase <= 1'b0;
               r_bit   <= '0;
            end
            S_SHIFT: begin
               if (w_div_last) begin
                  r_div   <= '0;
                  r_phase <= ~r_phase;
                  if (r_phase) begin
                     // Advance to the next column only after the high half,
                     // so sdata holds for the whole bit period.
                     r_shift <= r_shift << 1;
                     r_bit   <= r_bit + BIT_W'(1);
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            S_LATCH: begin
               r_dwell <= '0;
            end
            S_DWELL: begin
               r_dwell <= r_dwell + DWL_W'(1);
               if (w_dwell_last)
                  r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Next-state and Moore output decode
   always_comb begin
      w_next      = r_state;
      sclk        = 1'b0;
      sdata       = 1'b0;
      latch       = 1'b0;
      row_sel     = '0;
      blank       = 1'b1;
      frame_start = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) w_next = S_SNAP;
         end
         S_SNAP: begin
            frame_start = w_row_zero;
            w_next      = S_SHIFT;
         end
         S_SHIFT: begin
            sclk  = r_phase;
            sdata = r_shift[COLS-1];
            if (w_shift_done) w_next = S_LATCH;
         end
         S_LATCH: begin
            latch  = 1'b1;
            w_next = S_DWELL;
         end
         S_DWELL: begin
            blank   = 1'b0;
            row_sel = ROWS'(1) << r_row;
            if (w_dwell_last) w_next = enable ? S_SNAP : S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
